spdif_frame_formatter: RTL and testbench
========================================

Name: spdif_frame_formatter

Overview:
- Downstream consumer of the 192-bit S/PDIF channel status word.
- Accepts stereo sample pairs over a valid/ready handshake and tracks the 192-frame block position.
- Emits one 28-bit subframe payload per channel (time slots 4..31: audio, V, U, C, P) with a preamble code, for the biphase-mark line encoder.
- Selects the channel status bit for each frame and computes even parity.

Parameters:
- SAMPLE_WIDTH, 24: input sample width in bits (16..24). Samples are MSB-justified into the 24-bit audio field and the unused LSBs are zero.

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- channelStatus  in  192  channel status word; bit n is sent in frame n
- validityFlag  in  1  V bit applied to both subframes of the accepted pair
- resyncBlock  in  1  force block restart (frame index to 0)
- sampleLeft  in  SAMPLE_WIDTH  left sample, two's complement
- sampleRight  in  SAMPLE_WIDTH  right sample
- sampleValid  in  1  sample pair valid
- sampleReady  out  1  pair accepted when sampleValid & sampleReady
- subframeData  out  28  [23:0] audio (bit0 = slot 4, LSB), [24] V, [25] U, [26] C, [27] P
- preamble  out  2  0 = B (block start, left), 1 = M (left), 2 = W (right); 3 never driven
- subframeValid  out  1  subframe output valid
- subframeReady  in  1  downstream accepts when subframeValid & subframeReady
- frameIndex  out  8  index of the frame currently presented (0..191)

Behaviour:
- Reset (asynchronous, active-high) values:
  - state = IDLE
  - sampleReady = 0, subframeValid = 0
  - subframeData = 0, preamble = 0
  - frameIndex = 0
  - latched status register = 0, resync-pending flag = 0
- All outputs are registered. sampleReady rises on the first clk edge after reset deasserts.
- State machine:
  - IDLE
    - sampleReady = 1.
    - On accept: latch both samples and validityFlag. If frameIndex == 0, also latch channelStatus into the status register. Go to LEFT.
    - Next cycle: sampleReady = 0, subframeValid = 1.
  - LEFT
    - Present the left subframe. preamble = B if frameIndex == 0, else M.
    - Hold all outputs stable until subframeReady. On handshake, present the right subframe in the following cycle. Go to RIGHT.
  - RIGHT
    - Present the right subframe with preamble = W.
    - On handshake: subframeValid = 0, frameIndex = (frameIndex == 191) ? 0 : frameIndex + 1. Go to IDLE.
- Latency: the left subframe is valid 1 cycle after the accept. Minimum 3 cycles per frame with no backpressure.
- Subframe fields:
  - audio[23:0] = sample << (24 - SAMPLE_WIDTH).
  - U = 0.
  - C = status register bit [frameIndex]. The same bit is used in both subframes; channel number 0 is mandated system-wide.
  - P = XOR of subframeData[26:0], so slots 4..31 carry an even number of ones.
- Status word latching:
  - channelStatus is sampled only on the accept of frame 0.
  - Changes mid-block take effect at the next block.
- resyncBlock:
  - Sampled every cycle.
  - In IDLE: frameIndex <= 0 immediately. If asserted in the same cycle as an accept, the accepted pair becomes frame 0 and channelStatus is latched.
  - In LEFT/RIGHT: set resync-pending. At the RIGHT handshake, frameIndex <= 0 instead of incrementing, and pending clears.
  - The current frame is never truncated.
- Wrap: after frame 191, the next frame is 0 and carries preamble B with a freshly latched status word.
- Backpressure: while subframeValid & !subframeReady, subframeData, preamble and frameIndex are held unchanged.
- Reset mid-operation: any in-flight subframe is dropped, subframeValid falls immediately (asynchronously), and the next frame after reset is frame 0.

Test Plan:
- Reset release, then SAMPLE_WIDTH=24, channelStatus bit0=0, left=24'h000001, right=24'h000003, V=0, ready held 1:
  - left subframeData=28'h8000001, preamble=B, frameIndex=0
  - right subframeData=28'h0000003, preamble=W
- channelStatus[2:0]=3'b100, 3 pairs of zero samples:
  - frame 2 subframes both 28'hC000000 (C=1, P=1), preambles M then W
  - frames 0/1 are 28'h0000000
- 193 consecutive pairs:
  - frameIndex runs 0..191 then 0
  - preamble B only on frames 0 and 192
  - channelStatus changed at frame 100 is ignored until frame 192
- subframeReady held low 5 cycles during LEFT of frame 7:
  - outputs stable, no extra frame accepted (sampleReady=0)
  - right subframe follows only after handshake
- resyncBlock pulsed during RIGHT of frame 50:
  - next accepted pair is frame 0 with preamble B and a newly latched status word
- SAMPLE_WIDTH=16, left=16'h8000:
  - audio field=24'h800000, P=1, subframeData=28'h8800000
- Reset asserted while in LEFT:
  - subframeValid=0 immediately
  - after release the next frame is 0 with preamble B

Source files
------------

// File: rtl/spdif_frame_formatter.sv
// S/PDIF subframe formatter: turns accepted stereo pairs into left/right 28-bit
// subframe payloads with preamble codes, channel status bit and even parity.
module spdif_frame_formatter #(
   parameter int SAMPLE_WIDTH = 24
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [191:0]            channelStatus,
   input  logic                    validityFlag,
   input  logic                    resyncBlock,
   input  logic [SAMPLE_WIDTH-1:0] sampleLeft,
   input  logic [SAMPLE_WIDTH-1:0] sampleRight,
   input  logic                    sampleValid,
   output logic                    sampleReady,
   output logic [27:0]             subframeData,
   output logic [1:0]              preamble,
   output logic                    subframeValid,
   input  logic                    subframeReady,
   output logic [7:0]              frameIndex
);

   localparam int AUDIO_SHIFT = 24 - SAMPLE_WIDTH;
   localparam logic [1:0] PRE_B = 2'd0;
   localparam logic [1:0] PRE_M = 2'd1;
   localparam logic [1:0] PRE_W = 2'd2;

   typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

   state_t       state;
   logic [191:0] statusReg;
   logic         resyncPending;
   logic [23:0]  rightAudio;
   logic         heldV;
   logic         heldC;

   logic [23:0]  leftAudioIn;
   logic [23:0]  rightAudioIn;
   logic [7:0]   acceptIdx;
   logic [191:0] acceptStatus;
   logic         acceptC;
   logic [7:0]   nextIndex;

   // Body is slots 4..30; the top bit makes the whole 28-bit payload even.
   function automatic logic [27:0] packSubframe(input logic [23:0] audio,
                                                input logic v,
                                                input logic c);
      logic [26:0] body;
      body = {c, 1'b0, v, audio};
      return {^body, body};
   endfunction

   // A resync seen on the accept cycle turns this pair into frame 0, so the
   // fresh status word (not the stale register) supplies its C bit.
   always_comb begin
      leftAudioIn  = 24'(sampleLeft) << AUDIO_SHIFT;
      rightAudioIn = 24'(sampleRight) << AUDIO_SHIFT;
      acceptIdx    = resyncBlock ? 8'd0 : frameIndex;
      acceptStatus = (acceptIdx == 8'd0) ? channelStatus : statusReg;
      acceptC      = acceptStatus[acceptIdx];
      nextIndex    = (resyncPending || resyncBlock || frameIndex == 8'd191) ?
                     8'd0 : frameIndex + 8'd1;
   end

   // Frame sequencer: IDLE takes a pair, LEFT and RIGHT each wait for the
   // downstream handshake before moving on, so a frame is never truncated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         sampleReady   <= 1'b0;
         subframeValid <= 1'b0;
         subframeData  <= '0;
         preamble      <= PRE_B;
         frameIndex    <= '0;
         statusReg     <= '0;
         resyncPending <= 1'b0;
         rightAudio    <= '0;
         heldV         <= 1'b0;
         heldC         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               sampleReady <= 1'b1;
               if (resyncBlock)
                  frameIndex <= 8'd0;
               if (sampleValid && sampleReady) begin
                  sampleReady   <= 1'b0;
                  frameIndex    <= acceptIdx;
                  if (acceptIdx == 8'd0)
                     statusReg <= channelStatus;
                  rightAudio    <= rightAudioIn;
                  heldV         <= validityFlag;
                  heldC         <= acceptC;
                  subframeData  <= packSubframe(leftAudioIn, validityFlag, acceptC);
                  preamble      <= (acceptIdx == 8'd0) ? PRE_B : PRE_M;
                  subframeValid <= 1'b1;
                  state         <= LEFT;
               end
            end
            LEFT: begin
               if (resyncBlock)
                  resyncPending <= 1'b1;
               if (subframeReady) begin
                  subframeData <= packSubframe(rightAudio, heldV, heldC);
                  preamble     <= PRE_W;
                  state        <= RIGHT;
               end
            end
            RIGHT: begin
               if (resyncBlock)
                  resyncPending <= 1'b1;
               if (subframeReady) begin
                  subframeValid <= 1'b0;
                  sampleReady   <= 1'b1;
                  frameIndex    <= nextIndex;
                  resyncPending <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spdif_frame_formatter.sv
// Randomized self-checking bench for spdif_frame_formatter; a frame-level
// reference model tracks block position, status latching and expected words.
module tb_spdif_frame_formatter;

   logic         clk = 1'b0;
   logic         reset;
   logic [191:0] channelStatus;
   logic         validityFlag;
   logic         resyncBlock;
   logic [23:0]  sampleLeft;
   logic [23:0]  sampleRight;
   logic         sampleValid;
   logic         sampleReady;
   logic [27:0]  subframeData;
   logic [1:0]   preamble;
   logic         subframeValid;
   logic         subframeReady;
   logic [7:0]   frameIndex;

   logic [15:0]  s16Left;
   logic [15:0]  s16Right;
   logic         s16Valid;
   logic         s16Ready;
   logic [27:0]  s16Data;
   logic [1:0]   s16Pre;
   logic         s16SfValid;
   logic         s16SfReady;
   logic [7:0]   s16Index;
   logic         s16Resync;

   int total = 0;
   int bad = 0;

   int           mIdx;
   logic [191:0] mStatus;
   logic [1:0]   lastPre;
   logic [27:0]  obsLeft;
   logic [27:0]  obsRight;
   logic [7:0]   obsIdx;

   spdif_frame_formatter #(.SAMPLE_WIDTH(24)) dut (
      .clk(clk), .reset(reset), .channelStatus(channelStatus),
      .validityFlag(validityFlag), .resyncBlock(resyncBlock),
      .sampleLeft(sampleLeft), .sampleRight(sampleRight),
      .sampleValid(sampleValid), .sampleReady(sampleReady),
      .subframeData(subframeData), .preamble(preamble),
      .subframeValid(subframeValid), .subframeReady(subframeReady),
      .frameIndex(frameIndex)
   );

   spdif_frame_formatter #(.SAMPLE_WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .channelStatus(channelStatus),
      .validityFlag(1'b0), .resyncBlock(s16Resync),
      .sampleLeft(s16Left), .sampleRight(s16Right),
      .sampleValid(s16Valid), .sampleReady(s16Ready),
      .subframeData(s16Data), .preamble(s16Pre),
      .subframeValid(s16SfValid), .subframeReady(s16SfReady),
      .frameIndex(s16Index)
   );

   always #5 clk = ~clk;

   // Expected payload: audio, V at 24, C at 26, then parity so the count of ones is even.
   function automatic logic [27:0] refWord(input logic [23:0] audio, input logic v, input logic c);
      logic [27:0] w;
      w = 28'(audio);
      w[24] = v;
      w[26] = c;
      w[27] = ($countones(w) % 2 == 1);
      return w;
   endfunction

   function automatic logic [191:0] randStatus();
      logic [191:0] s;
      for (int i = 0; i < 6; i++) s[i*32 +: 32] = $urandom;
      return s;
   endfunction

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      sampleValid = 1'b0;
      resyncBlock = 1'b0;
      s16Valid = 1'b0;
      subframeReady = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mIdx = 0;
      mStatus = '0;
   endtask

   // Sends one pair through the 24-bit DUT and checks both subframes against the model.
   task automatic driveFrame(input logic [23:0] l, input logic [23:0] r, input logic v,
                             input int stall, input logic resyncRight);
      logic [27:0] expL, expR;
      logic [1:0]  expPre;
      logic        c;
      int          w;
      @(negedge clk);
      sampleLeft = l; sampleRight = r; validityFlag = v; sampleValid = 1'b1;
      w = 0;
      while (!sampleReady && w < 20) begin
         @(negedge clk);
         w++;
      end
      total++;
      if (sampleReady !== 1'b1) begin
         bad++;
         $display("[TB] FAIL accept_timeout got=%b want=1", sampleReady);
         sampleValid = 1'b0;
         return;
      end
      if (mIdx == 0) mStatus = channelStatus;
      c = mStatus[mIdx];
      expL = refWord(l, v, c);
      expR = refWord(r, v, c);
      expPre = (mIdx == 0) ? 2'd0 : 2'd1;
      @(negedge clk);
      sampleValid = 1'b0;
      total++;
      if (subframeValid !== 1'b1 || sampleReady !== 1'b0) begin
         bad++;
         $display("[TB] FAIL left_handshake frame=%0d got valid=%b ready=%b want valid=1 ready=0",
                  mIdx, subframeValid, sampleReady);
      end
      total++;
      if (subframeData !== expL || preamble !== expPre || frameIndex !== 8'(mIdx)) begin
         bad++;
         $display("[TB] FAIL left_word frame=%0d got data=%h pre=%0d idx=%0d want data=%h pre=%0d idx=%0d",
                  mIdx, subframeData, preamble, frameIndex, expL, expPre, mIdx);
      end
      lastPre = preamble;
      obsLeft = subframeData;
      obsIdx = frameIndex;
      if (stall > 0) subframeReady = 1'b0;
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         if (k == stall - 1) subframeReady = 1'b1;
         total++;
         if (subframeData !== expL || preamble !== expPre || frameIndex !== 8'(mIdx) ||
             subframeValid !== 1'b1 || sampleReady !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_hold cycle=%0d got data=%h pre=%0d idx=%0d v=%b rdy=%b want data=%h pre=%0d idx=%0d v=1 rdy=0",
                     k, subframeData, preamble, frameIndex, subframeValid, sampleReady, expL, expPre, mIdx);
         end
      end
      @(negedge clk);
      total++;
      if (subframeData !== expR || preamble !== 2'd2 || subframeValid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL right_word frame=%0d got data=%h pre=%0d v=%b want data=%h pre=2 v=1",
                  mIdx, subframeData, preamble, subframeValid, expR);
      end
      obsRight = subframeData;
      if (resyncRight) resyncBlock = 1'b1;
      @(negedge clk);
      resyncBlock = 1'b0;
      mIdx = (resyncRight || mIdx == 191) ? 0 : mIdx + 1;
      total++;
      if (subframeValid !== 1'b0 || sampleReady !== 1'b1 || frameIndex !== 8'(mIdx)) begin
         bad++;
         $display("[TB] FAIL frame_end got v=%b rdy=%b idx=%0d want v=0 rdy=1 idx=%0d",
                  subframeValid, sampleReady, frameIndex, mIdx);
      end
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (sampleReady !== 1'b0 || subframeValid !== 1'b0 || subframeData !== 28'h0 ||
          preamble !== 2'd0 || frameIndex !== 8'd0) begin
         bad++;
         $display("[TB] FAIL reset_values got rdy=%b v=%b data=%h pre=%0d idx=%0d want all zero",
                  sampleReady, subframeValid, subframeData, preamble, frameIndex);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (sampleReady !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ready_after_reset got=%b want=1", sampleReady);
      end
   endtask

   task automatic test_basic();
      channelStatus = randStatus();
      channelStatus[0] = 1'b0;
      driveFrame(24'h000001, 24'h000003, 1'b0, 0, 1'b0);
      total++;
      if (obsLeft !== 28'h8000001 || obsRight !== 28'h0000003 || lastPre !== 2'd0 || obsIdx !== 8'd0) begin
         bad++;
         $display("[TB] FAIL basic_literal got left=%h right=%h pre=%0d idx=%0d want left=8000001 right=0000003 pre=0 idx=0",
                  obsLeft, obsRight, lastPre, obsIdx);
      end
      for (int i = 0; i < 4; i++)
         driveFrame(24'($urandom), 24'($urandom), 1'($urandom), 0, 1'b0);
   endtask

   task automatic test_status_bits();
      doReset();
      channelStatus = '0;
      channelStatus[2:0] = 3'b100;
      for (int f = 0; f < 3; f++) begin
         driveFrame(24'h0, 24'h0, 1'b0, 0, 1'b0);
         total++;
         if (obsLeft !== ((f == 2) ? 28'hC000000 : 28'h0) || obsRight !== obsLeft) begin
            bad++;
            $display("[TB] FAIL status_bit frame=%0d got left=%h right=%h want=%h",
                     f, obsLeft, obsRight, (f == 2) ? 28'hC000000 : 28'h0);
         end
      end
   endtask

   task automatic test_block_wrap();
      int countB;
      doReset();
      channelStatus = randStatus();
      countB = 0;
      for (int f = 0; f < 193; f++) begin
         if (f == 100) channelStatus = randStatus();
         driveFrame(24'($urandom), 24'($urandom), 1'($urandom), 0, 1'b0);
         if (lastPre == 2'd0) countB++;
      end
      total++;
      if (countB != 2 || obsIdx !== 8'd0 || frameIndex !== 8'd1) begin
         bad++;
         $display("[TB] FAIL block_wrap got bCount=%0d lastIdx=%0d idx=%0d want bCount=2 lastIdx=0 idx=1",
                  countB, obsIdx, frameIndex);
      end
   endtask

   task automatic test_backpressure();
      doReset();
      channelStatus = randStatus();
      for (int f = 0; f < 7; f++)
         driveFrame(24'($urandom), 24'($urandom), 1'($urandom), 0, 1'b0);
      driveFrame(24'($urandom), 24'($urandom), 1'($urandom), 5, 1'b0);
   endtask

   task automatic test_resync();
      while (mIdx < 50)
         driveFrame(24'($urandom), 24'($urandom), 1'($urandom), 0, 1'b0);
      driveFrame(24'($urandom), 24'($urandom), 1'($urandom), 0, 1'b1);
      channelStatus = randStatus();
      driveFrame(24'($urandom), 24'($urandom), 1'($urandom), 0, 1'b0);
      total++;
      if (lastPre !== 2'd0 || obsIdx !== 8'd0) begin
         bad++;
         $display("[TB] FAIL resync_restart got pre=%0d idx=%0d want pre=0 idx=0", lastPre, obsIdx);
      end
   endtask

   task automatic test_width16();
      logic [27:0] expR;
      int w;
      doReset();
      channelStatus = '0;
      @(negedge clk);
      s16Left = 16'h8000;
      s16Right = 16'($urandom);
      s16Valid = 1'b1;
      w = 0;
      while (!s16Ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      s16Valid = 1'b0;
      total++;
      if (s16Data !== 28'h8800000 || s16Pre !== 2'd0 || s16SfValid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL width16_left got data=%h pre=%0d v=%b want data=8800000 pre=0 v=1",
                  s16Data, s16Pre, s16SfValid);
      end
      expR = refWord(24'(s16Right) * 24'd256, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (s16Data !== expR || s16Pre !== 2'd2) begin
         bad++;
         $display("[TB] FAIL width16_right got data=%h pre=%0d want data=%h pre=2", s16Data, s16Pre, expR);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      doReset();
      channelStatus = randStatus();
      driveFrame(24'($urandom), 24'($urandom), 1'b0, 0, 1'b0);
      @(negedge clk);
      sampleLeft = 24'($urandom);
      sampleValid = 1'b1;
      @(negedge clk);
      sampleValid = 1'b0;
      total++;
      if (subframeValid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL mid_left_valid got=%b want=1", subframeValid);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if (subframeValid !== 1'b0 || frameIndex !== 8'd0) begin
         bad++;
         $display("[TB] FAIL async_drop got v=%b idx=%0d want v=0 idx=0", subframeValid, frameIndex);
      end
      @(negedge clk);
      reset = 1'b0;
      mIdx = 0;
      channelStatus = randStatus();
      driveFrame(24'($urandom), 24'($urandom), 1'($urandom), 0, 1'b0);
      total++;
      if (lastPre !== 2'd0 || obsIdx !== 8'd0) begin
         bad++;
         $display("[TB] FAIL after_reset_frame got pre=%0d idx=%0d want pre=0 idx=0", lastPre, obsIdx);
      end
   endtask

   initial begin
      reset = 1'b1;
      channelStatus = '0;
      validityFlag = 1'b0;
      resyncBlock = 1'b0;
      sampleLeft = '0;
      sampleRight = '0;
      sampleValid = 1'b0;
      subframeReady = 1'b1;
      s16Left = '0;
      s16Right = '0;
      s16Valid = 1'b0;
      s16SfReady = 1'b1;
      s16Resync = 1'b0;
      mIdx = 0;
      mStatus = '0;
      test_reset();
      test_basic();
      test_status_bits();
      test_block_wrap();
      test_backpressure();
      test_resync();
      test_width16();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
